// File: rtl/noc_inject_queue.sv
// Injection queue feeding the NoC switch self port: buffers INDEX/DATA packet pairs and sends
// them flit by flit on grant. Optional stall counter enabled by NOC_INJECT_STALL_CNT_EN.
`ifndef GOLOBAL_DATA_BUS_WIDTH_CONFIG
`define GOLOBAL_DATA_BUS_WIDTH_CONFIG 16
`endif

module noc_inject_queue #(
  parameter int unsigned GOLOBAL_DATA_BUS_WIDTH = `GOLOBAL_DATA_BUS_WIDTH_CONFIG,
  parameter int unsigned DEPTH                  = 4,
  parameter int unsigned PTR_WIDTH              = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH              = PTR_WIDTH + 1
`ifdef NOC_INJECT_STALL_CNT_EN
  ,
  parameter int unsigned STALL_CNT_WIDTH        = 16
`endif
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inValid,
  input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] inIndex,
  input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] inData,
  output logic                              inReady,
  output logic [GOLOBAL_DATA_BUS_WIDTH-1:0] selfData,
  output logic                              selfReq,
  input  logic                              grat2self,
  output logic [CNT_WIDTH-1:0]              occupancy
`ifdef NOC_INJECT_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0]        stallCount
`endif
);

  typedef enum logic [1:0] {StIdle, StSendIndex, StSendData} state_e;

  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] index_q [DEPTH];
  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] data_q  [DEPTH];
  logic [PTR_WIDTH-1:0]              wrptr_q, wrptr_d;
  logic [PTR_WIDTH-1:0]              rdptr_q, rdptr_d;
  logic [CNT_WIDTH-1:0]              occupancy_q, occupancy_d;
  state_e                            state_q;
  logic                              launch_q;
  logic                              req_q;
  logic                              push, pop;

  assign inReady   = (occupancy_q != CNT_WIDTH'(DEPTH));
  assign push      = inValid & inReady;
  assign pop       = (state_q == StSendData) & grat2self;
  assign occupancy = occupancy_q;
  assign selfReq   = req_q;

  always_comb begin
    wrptr_d     = push ? wrptr_q + PTR_WIDTH'(1) : wrptr_q;
    rdptr_d     = pop ? rdptr_q + PTR_WIDTH'(1) : rdptr_q;
    occupancy_d = occupancy_q;
    if (push && !pop) begin
      occupancy_d = occupancy_q + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      occupancy_d = occupancy_q - CNT_WIDTH'(1);
    end
  end

  // Flit storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      index_q[wrptr_q] <= inIndex;
      data_q[wrptr_q]  <= inData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      occupancy_q <= '0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      occupancy_q <= occupancy_d;
    end
  end

  // IDLE spends one cycle noticing a non-empty queue before launching, so a push into an
  // empty queue raises selfReq on the second edge after the push edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      launch_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (launch_q) begin
            state_q  <= StSendIndex;
            req_q    <= 1'b1;
            launch_q <= 1'b0;
          end else if (occupancy_q != '0) begin
            launch_q <= 1'b1;
          end
        end
        StSendIndex: begin
          if (grat2self) begin
            state_q <= StSendData;
          end
        end
        StSendData: begin
          if (grat2self) begin
            if (occupancy_d != '0) begin
              state_q <= StSendIndex;
            end else begin
              state_q <= StIdle;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          req_q    <= 1'b0;
          launch_q <= 1'b0;
        end
      endcase
    end
  end

  // Head entry cannot be overwritten while non-empty, so selfData holds steady under stall.
  always_comb begin
    selfData = '0;
    unique case (state_q)
      StSendIndex: selfData = index_q[rdptr_q];
      StSendData:  selfData = data_q[rdptr_q];
      default:     selfData = '0;
    endcase
  end

`ifdef NOC_INJECT_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (req_q && !grat2self && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign stallCount = stall_q;
`endif

endmodule

// File: tb/tb_noc_inject_queue.sv
// Directed self-checking bench for noc_inject_queue (DEPTH=4, 16-bit flits).
`timescale 1ns/1ps

module tb_noc_inject_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [15:0] inIndex;
  logic [15:0] inData;
  logic        inReady;
  logic [15:0] selfData;
  logic        selfReq;
  logic        grat2self;
  logic [2:0]  occupancy;
`ifdef NOC_INJECT_STALL_CNT_EN
  logic [3:0]  stallCount;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        saw_req;

  always #5 clk = ~clk;

  noc_inject_queue #(
    .GOLOBAL_DATA_BUS_WIDTH(16),
    .DEPTH(4)
`ifdef NOC_INJECT_STALL_CNT_EN
    ,
    .STALL_CNT_WIDTH(4)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .inValid(inValid),
    .inIndex(inIndex),
    .inData(inData),
    .inReady(inReady),
    .selfData(selfData),
    .selfReq(selfReq),
    .grat2self(grat2self),
    .occupancy(occupancy)
`ifdef NOC_INJECT_STALL_CNT_EN
    ,
    .stallCount(stallCount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] idx, input logic [15:0] dat);
    inValid = v;
    inIndex = idx;
    inData  = dat;
  endtask

  initial begin
    reset = 1'b0;
    grat2self = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("rst_req", {31'b0, selfReq}, 32'd0);
    chk("rst_data", {16'b0, selfData}, 32'h0);
    chk("rst_occ", {29'b0, occupancy}, 32'd0);
    chk("rst_ready", {31'b0, inReady}, 32'd1);
    reset = 1'b1;
    step();

    // Single packet, grant held high.
    grat2self = 1'b1;
    drive(1'b1, 16'h0100, 16'hBEEF);
    step();
    drive(1'b0, 16'h0, 16'h0);
    chk("p1_occ_after_push", {29'b0, occupancy}, 32'd1);
    chk("p1_req_edge1", {31'b0, selfReq}, 32'd0);
    step();
    chk("p1_req_edge1b", {31'b0, selfReq}, 32'd0);
    step();
    chk("p1_req_edge2", {31'b0, selfReq}, 32'd1);
    chk("p1_index", {16'b0, selfData}, 32'h0100);
    step();
    chk("p1_data", {16'b0, selfData}, 32'hBEEF);
    chk("p1_data_req", {31'b0, selfReq}, 32'd1);
    step();
    chk("p1_idle_req", {31'b0, selfReq}, 32'd0);
    chk("p1_idle_data", {16'b0, selfData}, 32'h0);
    chk("p1_idle_occ", {29'b0, occupancy}, 32'd0);

    // Back-pressure: five ungranted cycles in SEND_INDEX.
    grat2self = 1'b0;
    drive(1'b1, 16'h0200, 16'h0201);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    step();
    chk("bp_req_start", {31'b0, selfReq}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", {16'b0, selfData}, 32'h0200);
      chk("bp_hold_req", {31'b0, selfReq}, 32'd1);
    end
`ifdef NOC_INJECT_STALL_CNT_EN
    chk("bp_stall", {28'b0, stallCount}, 32'd5);
`endif
    grat2self = 1'b1;
    step();
    chk("bp_data", {16'b0, selfData}, 32'h0201);
    step();
    chk("bp_drained", {29'b0, occupancy}, 32'd0);

    // Fill and overflow with no grant.
    grat2self = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 16'h0300 + 16'(k), 16'h0400 + 16'(k));
      step();
      chk("fill_ready", {31'b0, inReady}, (k >= 4) ? 32'd0 : 32'd1);
      chk("fill_occ", {29'b0, occupancy}, (k >= 4) ? 32'd4 : 32'(k));
    end
    drive(1'b0, 16'h0, 16'h0);
    grat2self = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_index", {16'b0, selfData}, 32'h0300 + 32'(k));
      step();
      chk("drain_data", {16'b0, selfData}, 32'h0400 + 32'(k));
      step();
    end
    chk("drain_req", {31'b0, selfReq}, 32'd0);
    chk("drain_occ", {29'b0, occupancy}, 32'd0);
    chk("drain_ready", {31'b0, inReady}, 32'd1);

    // Streaming at occupancy 2 across pointer wrap.
    grat2self = 1'b0;
    drive(1'b1, 16'h0500, 16'h0600);
    step();
    drive(1'b1, 16'h0501, 16'h0601);
    step();
    drive(1'b0, 16'h0, 16'h0);
    grat2self = 1'b1;
    step();
    chk("wrap_req", {31'b0, selfReq}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk("wrap_index", {16'b0, selfData}, 32'h0500 + 32'(k));
      chk("wrap_occ", {29'b0, occupancy}, (k <= 8) ? 32'd2 : 32'd1);
      step();
      chk("wrap_data", {16'b0, selfData}, 32'h0600 + 32'(k));
      if (k + 2 < 10) drive(1'b1, 16'h0500 + 16'(k + 2), 16'h0600 + 16'(k + 2));
      step();
      drive(1'b0, 16'h0, 16'h0);
    end
    chk("wrap_end_req", {31'b0, selfReq}, 32'd0);
    chk("wrap_end_occ", {29'b0, occupancy}, 32'd0);

    // Asynchronous reset in SEND_DATA with three queued packets.
    grat2self = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0700 + 16'(k), 16'h0800 + 16'(k));
      step();
    end
    drive(1'b0, 16'h0, 16'h0);
    grat2self = 1'b1;
    step();
    grat2self = 1'b0;
    chk("mid_data", {16'b0, selfData}, 32'h0800);
    chk("mid_occ", {29'b0, occupancy}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_req", {31'b0, selfReq}, 32'd0);
    chk("async_occ", {29'b0, occupancy}, 32'd0);
    chk("async_data", {16'b0, selfData}, 32'h0);
    chk("async_ready", {31'b0, inReady}, 32'd1);
    step();
    reset = 1'b1;
    grat2self = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (selfReq) saw_req = 1'b1;
    end
    chk("post_rst_quiet", {31'b0, saw_req}, 32'd0);
    chk("post_rst_occ", {29'b0, occupancy}, 32'd0);

`ifdef NOC_INJECT_STALL_CNT_EN
    // Stall counter saturation at 4 bits.
    chk("sat_start", {28'b0, stallCount}, 32'd0);
    grat2self = 1'b0;
    drive(1'b1, 16'h0900, 16'h0901);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    step();
    for (int i = 0; i < 20; i++) step();
    chk("sat_20", {28'b0, stallCount}, 32'd15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", {28'b0, stallCount}, 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
